// File: rtl/outarb_pkg.sv
// outarb shared definitions: flit types, port widths, arbiter states.
// Imported by the arbiter top and its round-robin picker.
package outarb_pkg;

  localparam int PORTW = 2;
  localparam int TYPEW = 1;

  localparam logic [TYPEW:0] TYPE_HEAD     = 2'd0;
  localparam logic [TYPEW:0] TYPE_BODY     = 2'd1;
  localparam logic [TYPEW:0] TYPE_TAIL     = 2'd2;
  localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'd3;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [1:0] OWNER_NONE = 2'd3;
  localparam logic [1:0] LST_RST    = 2'd2;
  localparam logic [7:0] WD_MAX     = 8'hFF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  function automatic logic is_tail(
    input logic [TYPEW:0] t
  );
    return (t == TYPE_TAIL) ||
           (t == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/outarb_rrpick.sv
// outarb round-robin picker: first candidate after
// the last winner, scanning lst+1, lst+2, lst+3 mod 3.
module outarb_rrpick
  import outarb_pkg::*;
(
  input  logic [2:0] cand_i,
  input  logic [1:0] lst_i,
  output logic       hit_o,
  output logic [1:0] win_o
);

  logic [1:0] p0;
  logic [1:0] p1;
  logic [1:0] p2;

  // Scan order derived from the last winner.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    unique case (lst_i)
      2'd0: begin
        p0 = 2'd1;
        p1 = 2'd2;
        p2 = 2'd0;
      end
      2'd1: begin
        p0 = 2'd2;
        p1 = 2'd0;
        p2 = 2'd1;
      end
      default: begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
      end
    endcase
  end

  // First candidate in scan order wins.
  always_comb begin
    hit_o = |cand_i;
    win_o = 2'd0;
    if (cand_i[p0])
      win_o = p0;
    else if (cand_i[p1])
      win_o = p1;
    else if (cand_i[p2])
      win_o = p2;
  end

endmodule

// File: rtl/outarb.sv
// outarb: per-output-port switch arbiter with round-robin
// grant, packet-long hold and idle watchdog release.
module outarb
  import outarb_pkg::*;
#(
  parameter int PORTID  = 0,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           req_0,
  input  logic           req_1,
  input  logic           req_2,
  input  logic [PORTW:0] port_0,
  input  logic [PORTW:0] port_1,
  input  logic [PORTW:0] port_2,
  input  logic           ivalid_0,
  input  logic           ivalid_1,
  input  logic           ivalid_2,
  input  logic [TYPEW:0] itype_0,
  input  logic [TYPEW:0] itype_1,
  input  logic [TYPEW:0] itype_2,
  output logic           grt_0,
  output logic           grt_1,
  output logic           grt_2,
  output logic [1:0]     owner,
  output logic           busy,
  output logic           tmo
);

  localparam logic [PORTW:0] PID = PORTID[PORTW:0];
  localparam logic [7:0]     TO  = TIMEOUT[7:0];

  arb_state_e     state_q, state_d;
  logic [2:0]     grt_q, grt_d;
  logic [1:0]     owner_q, owner_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;
  logic [1:0]     lst_q, lst_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [2:0]     cand;
  logic           hit;
  logic [1:0]     win;
  logic           own_req;
  logic           own_vld;
  logic [TYPEW:0] own_typ;
  logic [7:0]     cnt_inc;
  logic [7:0]     cnt_nx;
  logic           rel_tail;
  logic           rel_abort;
  logic           rel_tmo;

  assign cand[0] = req_0 && (port_0 == PID);
  assign cand[1] = req_1 && (port_1 == PID);
  assign cand[2] = req_2 && (port_2 == PID);

  outarb_rrpick u_pick (
    .cand_i (cand),
    .lst_i  (lst_q),
    .hit_o  (hit),
    .win_o  (win)
  );

  // Select request and flit signals of the current owner.
  always_comb begin
    own_req = 1'b0;
    own_vld = 1'b0;
    own_typ = TYPE_HEAD;
    unique case (owner_q)
      2'd0: begin
        own_req = req_0;
        own_vld = ivalid_0;
        own_typ = itype_0;
      end
      2'd1: begin
        own_req = req_1;
        own_vld = ivalid_1;
        own_typ = itype_1;
      end
      2'd2: begin
        own_req = req_2;
        own_vld = ivalid_2;
        own_typ = itype_2;
      end
      default: begin
        own_req = 1'b0;
        own_vld = 1'b0;
        own_typ = TYPE_HEAD;
      end
    endcase
  end

  // Watchdog next value and the three release causes.
  always_comb begin
    cnt_inc   = (cnt_q == WD_MAX) ? cnt_q
                                  : cnt_q + 8'd1;
    cnt_nx    = own_vld ? 8'd0 : cnt_inc;
    rel_tail  = own_vld && is_tail(own_typ);
    rel_abort = !own_req;
    rel_tmo   = (cnt_nx == TO);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    lst_d   = lst_q;
    cnt_d   = cnt_q;
    tmo_d   = Disable;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = 8'd0;
        if (hit) begin
          state_d = ARB_HOLD;
          grt_d   = 3'b001 << win;
          owner_d = win;
          lst_d   = win;
          busy_d  = Enable;
        end
      end
      ARB_HOLD: begin
        if (rel_tail || rel_abort || rel_tmo) begin
          state_d = ARB_IDLE;
          grt_d   = 3'b000;
          owner_d = OWNER_NONE;
          busy_d  = Disable;
          cnt_d   = 8'd0;
          tmo_d   = !rel_tail && !rel_abort;
        end else begin
          cnt_d = cnt_nx;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ARB_IDLE;
      grt_q   <= 3'b000;
      owner_q <= OWNER_NONE;
      busy_q  <= Disable;
      tmo_q   <= Disable;
      lst_q   <= LST_RST;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      lst_q   <= lst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grt_0 = grt_q[0];
  assign grt_1 = grt_q[1];
  assign grt_2 = grt_q[2];
  assign owner = owner_q;
  assign busy  = busy_q;
  assign tmo   = tmo_q;

endmodule

// File: tb/tb_outarb.sv
// outarb bench: directed vectors with hand-computed
// grants, releases and watchdog pulses.
module tb_outarb;
  import outarb_pkg::*;

  localparam logic [PORTW:0] PID = 3'd1;
  localparam logic [PORTW:0] OTH = 3'd0;

  logic           clk  = 1'b0;
  logic           rst_ = 1'b1;
  logic           req [3];
  logic [PORTW:0] port [3];
  logic           vld [3];
  logic [TYPEW:0] typ [3];
  logic           g0, g1, g2;
  logic [2:0]     grt;
  logic [1:0]     owner;
  logic           busy;
  logic           tmo;

  int nvec = 0;
  int nerr = 0;

  assign grt = {g2, g1, g0};

  outarb #(
    .PORTID  (1),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req_0    (req[0]),
    .req_1    (req[1]),
    .req_2    (req[2]),
    .port_0   (port[0]),
    .port_1   (port[1]),
    .port_2   (port[2]),
    .ivalid_0 (vld[0]),
    .ivalid_1 (vld[1]),
    .ivalid_2 (vld[2]),
    .itype_0  (typ[0]),
    .itype_1  (typ[1]),
    .itype_2  (typ[2]),
    .grt_0    (g0),
    .grt_1    (g1),
    .grt_2    (g2),
    .owner    (owner),
    .busy     (busy),
    .tmo      (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      port[i] = PID;
      vld[i]  = 1'b0;
      typ[i]  = TYPE_HEAD;
    end
  endtask

  task automatic do_reset();
    idle_in();
    rst_ = 1'b0;
    step();
    step();
    rst_ = 1'b1;
  endtask

  // 4-flit packet from owner w while input o sends
  // stray TAIL flits that must be ignored.
  task automatic pkt(input int w, input int o);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d_%0d", w, k),
          32'(grt), 32'(1 << w));
      vld[w] = 1'b1;
      typ[w] = (k == 0) ? TYPE_HEAD :
               (k == 3) ? TYPE_TAIL : TYPE_BODY;
      vld[o] = 1'b1;
      typ[o] = TYPE_TAIL;
      step();
    end
    vld[w] = 1'b0;
    vld[o] = 1'b0;
    chk($sformatf("rel%0d", w), 32'(grt), 32'd0);
    chk($sformatf("relbusy%0d", w),
        32'(busy), 32'd0);
    step();
  endtask

  initial begin
    idle_in();
    #2;
    rst_ = 1'b0;
    #1;
    chk("rst_grt", 32'(grt), 32'd0);
    chk("rst_own", 32'(owner), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    step();
    step();
    rst_ = 1'b1;

    // lone request from input 1
    step();
    req[1] = 1'b1;
    step();
    chk("lone_grt", 32'(grt), 32'b010);
    chk("lone_own", 32'(owner), 32'd1);
    chk("lone_busy", 32'(busy), 32'd1);

    // three concurrent requesters
    do_reset();
    for (int i = 0; i < 3; i++) req[i] = 1'b1;
    step();
    chk("rr_own0", 32'(owner), 32'd0);
    pkt(0, 1);
    chk("rr_own1", 32'(owner), 32'd1);
    pkt(1, 2);
    chk("rr_own2", 32'(owner), 32'd2);
    pkt(2, 0);
    chk("rr_own0b", 32'(owner), 32'd0);
    pkt(0, 2);
    chk("rr_next1", 32'(grt), 32'b010);

    // HEADTAIL from owner 0, input 2 pending
    do_reset();
    req[0] = 1'b1;
    req[2] = 1'b1;
    step();
    chk("ht_grt0", 32'(grt), 32'b001);
    vld[0] = 1'b1;
    typ[0] = TYPE_HEADTAIL;
    step();
    vld[0] = 1'b0;
    chk("ht_rel", 32'(grt), 32'd0);
    chk("ht_tmo", 32'(tmo), 32'd0);
    step();
    chk("ht_grt2", 32'(grt), 32'b100);
    chk("ht_own2", 32'(owner), 32'd2);

    // abort, plus a requester for another port
    do_reset();
    req[0]  = 1'b1;
    req[1]  = 1'b1;
    port[1] = OTH;
    step();
    chk("ab_grt", 32'(grt), 32'b001);
    vld[0] = 1'b1;
    typ[0] = TYPE_HEAD;
    step();
    vld[0] = 1'b0;
    chk("ab_hold", 32'(grt), 32'b001);
    req[0] = 1'b0;
    step();
    chk("ab_rel", 32'(grt), 32'd0);
    chk("ab_tmo", 32'(tmo), 32'd0);
    chk("ab_own", 32'(owner), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("oth%0d", k), 32'(grt), 32'd0);
    end

    // watchdog: HEAD then stall, TIMEOUT 4
    do_reset();
    req[0] = 1'b1;
    step();
    chk("wd_grt", 32'(grt), 32'b001);
    vld[0] = 1'b1;
    typ[0] = TYPE_HEAD;
    step();
    vld[0] = 1'b0;
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("wd_hold%0d", k),
          32'(grt), 32'b001);
      chk($sformatf("wd_tmo%0d", k),
          32'(tmo), 32'd0);
      step();
    end
    chk("wd_rel", 32'(grt), 32'd0);
    chk("wd_pulse", 32'(tmo), 32'd1);
    chk("wd_own", 32'(owner), 32'd3);
    step();
    chk("wd_pend", 32'(tmo), 32'd0);
    chk("wd_regrt", 32'(grt), 32'b001);

    // reset asserted during HOLD
    do_reset();
    for (int i = 0; i < 3; i++) req[i] = 1'b1;
    step();
    pkt(0, 2);
    chk("mr_grt1", 32'(grt), 32'b010);
    vld[1] = 1'b1;
    typ[1] = TYPE_HEAD;
    step();
    vld[1] = 1'b0;
    #2;
    rst_ = 1'b0;
    #1;
    chk("mr_grt", 32'(grt), 32'd0);
    chk("mr_own", 32'(owner), 32'd3);
    chk("mr_busy", 32'(busy), 32'd0);
    step();
    rst_ = 1'b1;
    step();
    chk("mr_win0", 32'(grt), 32'b001);
    chk("mr_own0", 32'(owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
